// File: rtl/instruction_cache_assoc_pkg.sv
// Shared types and geometry helpers for the set-associative instruction cache.
package instruction_cache_assoc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_REFILL = 2'd2
    } state_e;

    // log2 of the number of sets for a given capacity, line size and associativity
    function automatic int set_bits(input int cache_l2, input int block_l2, input int ways_l2);
        return cache_l2 - block_l2 - ways_l2;
    endfunction

    // Keeps vector widths legal when a field degenerates to zero bits
    function automatic int pos_width(input int w);
        return (w > 0) ? w : 1;
    endfunction

endpackage

// File: rtl/instruction_cache_way.sv
// One way of the cache: per-set valid bit, tag and full line storage.
// Read is asynchronous on idx_i; write and clear take effect at the clock edge.
module instruction_cache_way #(
    parameter int NSETS  = 8,
    parameter int IDX_W  = 3,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 512
)(
    input  logic              clk_i,
    input  logic              clear_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              we_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [LINE_W-1:0] wr_line_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [LINE_W-1:0] rd_line_o
);

    logic [NSETS-1:0]  valid_q;
    logic [NSETS-1:0]  valid_d;
    logic [TAG_W-1:0]  tag_q  [NSETS];
    logic [LINE_W-1:0] line_q [NSETS];

    // Clear wins over a fill so reset/flush always leaves every set invalid
    always_comb begin
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = '0;
        end else if (we_i) begin
            valid_d[idx_i] = 1'b1;
        end
    end

    // Valid bits register
    always_ff @(posedge clk_i) begin
        valid_q <= valid_d;
    end

    // Tag and line storage, written only on fills
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[idx_i]  <= wr_tag_i;
            line_q[idx_i] <= wr_line_i;
        end
    end

    assign rd_valid_o = valid_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_line_o  = line_q[idx_i];

endmodule

// File: rtl/instruction_cache_assoc.sv
// N-way set-associative read-only instruction cache with refill FSM.
// Optional invalidate-all port pair enabled by INSTRUCTION_CACHE_FLUSH_EN.
module instruction_cache_assoc
    import instruction_cache_assoc_pkg::*;
#(
    parameter int L2_CACHE_SIZE = 10,
    parameter int L2_BLOCK_SIZE = 6,
    parameter int L2_ADDR_SIZE  = 32,
    parameter int L2_DATA_SIZE  = 2,
    parameter int L2_WAYS       = 1
)(
    input  logic                               CLK_I,
    input  logic                               RST_I,
    input  logic [(2**(L2_BLOCK_SIZE+3))-1:0]  inst_DAT_I,
    input  logic                               inst_ACK_I,
    output logic                               inst_CYC_O,
    output logic                               inst_STB_O,
    output logic [L2_ADDR_SIZE-1:0]            inst_ADR_O,
    input  logic                               inst_cache_CYC_I,
    input  logic                               inst_cache_STB_I,
    input  logic [L2_ADDR_SIZE-1:0]            inst_cache_ADR_I,
    output logic [(2**(L2_DATA_SIZE+3))-1:0]   inst_cache_DAT_O,
    output logic                               inst_cache_ACK_O
`ifdef INSTRUCTION_CACHE_FLUSH_EN
    ,
    input  logic                               flush_I,
    output logic                               flush_ACK_O
`endif
);

    localparam int SETS_L2 = set_bits(L2_CACHE_SIZE, L2_BLOCK_SIZE, L2_WAYS);
    localparam int IDX_W   = pos_width(SETS_L2);
    localparam int NSETS   = 1 << SETS_L2;
    localparam int NWAYS   = 1 << L2_WAYS;
    localparam int PTR_W   = pos_width(L2_WAYS);
    localparam int TAG_W   = L2_ADDR_SIZE - L2_BLOCK_SIZE - SETS_L2;
    localparam int LINE_W  = 1 << (L2_BLOCK_SIZE + 3);
    localparam int WORD_W  = 1 << (L2_DATA_SIZE + 3);
    localparam int AQ_W    = L2_ADDR_SIZE - L2_DATA_SIZE;
    localparam int WSEL_W  = L2_BLOCK_SIZE - L2_DATA_SIZE;

    state_e                  state_q, state_d;
    logic [AQ_W-1:0]         adr_q, adr_d;
    logic                    cyc_q, cyc_d;
    logic [L2_ADDR_SIZE-1:0] adr_o_q, adr_o_d;
    logic [PTR_W-1:0]        rr_q [NSETS];
    logic [PTR_W-1:0]        rr_d [NSETS];

    logic                    clear_all;
    logic                    fill;
    logic [IDX_W-1:0]        set_idx;
    logic [TAG_W-1:0]        tag;
    logic [WSEL_W-1:0]       word_sel;
    logic                    hit;
    logic                    any_invalid;
    logic [PTR_W-1:0]        victim;
    logic [LINE_W-1:0]       hit_line;

    logic                    way_valid [NWAYS];
    logic [TAG_W-1:0]        way_tag   [NWAYS];
    logic [LINE_W-1:0]       way_line  [NWAYS];

    // Latched address holds only the bits above the byte-in-word offset
    assign word_sel = adr_q[WSEL_W-1:0];
    assign set_idx  = (SETS_L2 > 0) ? adr_q[WSEL_W +: IDX_W] : '0;
    assign tag      = adr_q[AQ_W-1 -: TAG_W];

    for (genvar w = 0; w < NWAYS; w++) begin : g_way
        instruction_cache_way #(
            .NSETS  (NSETS),
            .IDX_W  (IDX_W),
            .TAG_W  (TAG_W),
            .LINE_W (LINE_W)
        ) u_way (
            .clk_i      (CLK_I),
            .clear_i    (RST_I | clear_all),
            .idx_i      (set_idx),
            .we_i       (fill && (victim == PTR_W'(w)) && !RST_I),
            .wr_tag_i   (tag),
            .wr_line_i  (inst_DAT_I),
            .rd_valid_o (way_valid[w]),
            .rd_tag_o   (way_tag[w]),
            .rd_line_o  (way_line[w])
        );
    end

    // Tag compare across the set and victim choice: lowest invalid way, else round-robin
    always_comb begin
        hit         = 1'b0;
        hit_line    = '0;
        any_invalid = 1'b0;
        victim      = rr_q[set_idx];
        for (int unsigned w = 0; w < NWAYS; w++) begin
            if (!way_valid[w] && !any_invalid) begin
                any_invalid = 1'b1;
                victim      = PTR_W'(w);
            end
            if (way_valid[w] && (way_tag[w] == tag)) begin
                hit      = 1'b1;
                hit_line = way_line[w];
            end
        end
    end

    // Requester-side response is combinational in the LOOKUP cycle
    assign inst_cache_ACK_O = (state_q == ST_LOOKUP) && inst_cache_CYC_I && hit;
    assign inst_cache_DAT_O = inst_cache_ACK_O ? hit_line[word_sel * WORD_W +: WORD_W] : '0;
    assign inst_CYC_O       = cyc_q;
    assign inst_STB_O       = cyc_q;
    assign inst_ADR_O       = adr_o_q;

    // Next-state logic for the IDLE / LOOKUP / REFILL controller
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        cyc_d     = cyc_q;
        adr_o_d   = adr_o_q;
        rr_d      = rr_q;
        clear_all = 1'b0;
        fill      = 1'b0;
        case (state_q)
            ST_IDLE: begin
`ifdef INSTRUCTION_CACHE_FLUSH_EN
                if (flush_I) begin
                    clear_all = 1'b1;
                end else
`endif
                if (inst_cache_CYC_I && inst_cache_STB_I) begin
                    adr_d   = inst_cache_ADR_I[L2_ADDR_SIZE-1:L2_DATA_SIZE];
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (!inst_cache_CYC_I || hit) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REFILL;
                    cyc_d   = 1'b1;
                    adr_o_d = {adr_q[AQ_W-1:WSEL_W], {L2_BLOCK_SIZE{1'b0}}};
                end
            end
            ST_REFILL: begin
                if (inst_ACK_I) begin
                    fill    = 1'b1;
                    cyc_d   = 1'b0;
                    state_d = ST_LOOKUP;
                    if (!any_invalid) begin
                        rr_d[set_idx] = (L2_WAYS == 0) ? '0 : rr_q[set_idx] + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear_all) begin
            for (int unsigned s = 0; s < NSETS; s++) begin
                rr_d[s] = '0;
            end
        end
    end

    // Controller state, refill bus outputs and replacement pointers
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            cyc_q   <= 1'b0;
            adr_o_q <= '0;
            for (int unsigned s = 0; s < NSETS; s++) begin
                rr_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cyc_q   <= cyc_d;
            adr_o_q <= adr_o_d;
            rr_q    <= rr_d;
        end
    end

`ifdef INSTRUCTION_CACHE_FLUSH_EN
    logic flush_ack_q, flush_ack_d;

    assign flush_ack_d = clear_all;
    assign flush_ACK_O = flush_ack_q;

    // Flush acknowledge pulses the cycle after the invalidate edge
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            flush_ack_q <= 1'b0;
        end else begin
            flush_ack_q <= flush_ack_d;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_cache_assoc.sv
// Randomised self-checking bench for instruction_cache_assoc (default geometry:
// 8 sets x 2 ways, 64-byte lines). Define INSTRUCTION_CACHE_FLUSH_EN to also
// exercise the flush port pair.
module tb_instruction_cache_assoc;

    logic         clk = 1'b0;
    logic         RST_I;
    logic [511:0] inst_DAT_I;
    logic         inst_ACK_I;
    logic         inst_CYC_O;
    logic         inst_STB_O;
    logic [31:0]  inst_ADR_O;
    logic         inst_cache_CYC_I;
    logic         inst_cache_STB_I;
    logic [31:0]  inst_cache_ADR_I;
    logic [31:0]  inst_cache_DAT_O;
    logic         inst_cache_ACK_O;
`ifdef INSTRUCTION_CACHE_FLUSH_EN
    logic         flush_I;
    logic         flush_ACK_O;
`endif

    int errors = 0;
    int checks = 0;

    // memory responder controls
    int  force_delay = -1;
    bit  real_ack;
    bit  prev_cyc;
    int  wait_cnt;

    // reference model: per-set tags in way positions plus replacement pointer
    bit          m_valid [8][2];
    logic [22:0] m_tag   [8][2];
    int          m_ptr   [8];

    always #5 clk = ~clk;

    instruction_cache_assoc dut (
        .CLK_I            (clk),
        .RST_I            (RST_I),
        .inst_DAT_I       (inst_DAT_I),
        .inst_ACK_I       (inst_ACK_I),
        .inst_CYC_O       (inst_CYC_O),
        .inst_STB_O       (inst_STB_O),
        .inst_ADR_O       (inst_ADR_O),
        .inst_cache_CYC_I (inst_cache_CYC_I),
        .inst_cache_STB_I (inst_cache_STB_I),
        .inst_cache_ADR_I (inst_cache_ADR_I),
        .inst_cache_DAT_O (inst_cache_DAT_O),
        .inst_cache_ACK_O (inst_cache_ACK_O)
`ifdef INSTRUCTION_CACHE_FLUSH_EN
        ,
        .flush_I          (flush_I),
        .flush_ACK_O      (flush_ACK_O)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] blk, input int w);
        if (blk == 32'h100 && w == 0) return 32'hDEADBEEF;
        return (blk * 32'h9E3779B1) ^ (32'(w) * 32'h85EBCA6B) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [511:0] line_of(input logic [31:0] blk);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = mem_word(blk, i);
        return l;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int s;
        s = int'(a[8:6]);
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == a[31:9]) return 1'b1;
        return 1'b0;
    endfunction

    // victim: lowest invalid way, otherwise the pointer, which then advances
    function automatic void model_fill(input logic [31:0] a);
        int s;
        int v;
        s = int'(a[8:6]);
        v = -1;
        for (int w = 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
        if (v < 0) begin
            v = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % 2;
        end
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = a[31:9];
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 8; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
        end
    endfunction

    // instruction memory: random (or forced) latency, stray ACKs while idle
    initial begin
        inst_ACK_I = 1'b0;
        inst_DAT_I = '0;
        real_ack   = 1'b0;
        prev_cyc   = 1'b0;
        wait_cnt   = 0;
        forever begin
            @(negedge clk);
            inst_ACK_I = 1'b0;
            real_ack   = 1'b0;
            if (inst_CYC_O && inst_STB_O) begin
                if (!prev_cyc) wait_cnt = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                if (wait_cnt == 0) begin
                    inst_ACK_I = 1'b1;
                    real_ack   = 1'b1;
                    inst_DAT_I = line_of(inst_ADR_O);
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                inst_ACK_I = 1'b1;
                inst_DAT_I = ~line_of($urandom() & 32'hFFFF_FFC0);
            end
            prev_cyc = inst_CYC_O;
        end
    end

    // One fetch. exp_hit: 1/0 = expected outcome, -1 = model decides only.
    // abort_at > 0: drop the request after that many refill cycles.
    task automatic do_read(input logic [31:0] addr, input int exp_hit, input int abort_at);
        bit hit_m;
        bit done;
        bit aborted;
        int ack_cyc;
        int consumed_cyc;
        int refill_cycles;
        hit_m         = model_hit(addr);
        done          = 1'b0;
        aborted       = 1'b0;
        ack_cyc       = 0;
        consumed_cyc  = 0;
        refill_cycles = 0;
        inst_cache_CYC_I = 1'b1;
        inst_cache_STB_I = 1'b1;
        inst_cache_ADR_I = addr;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(posedge clk);
            #1;
            if (real_ack) consumed_cyc = cyc;
            if (inst_CYC_O) begin
                refill_cycles++;
                check_eq("refill_adr", inst_ADR_O, addr & 32'hFFFF_FFC0);
                if (refill_cycles == 1) check_eq("refill_stb", 32'(inst_STB_O), 32'd1);
            end
            if (inst_cache_ACK_O && ack_cyc == 0) begin
                ack_cyc = cyc;
                check_eq("rd_data", inst_cache_DAT_O, mem_word(addr & 32'hFFFF_FFC0, int'(addr[5:2])));
            end
            if (abort_at > 0 && refill_cycles == abort_at && !aborted) begin
                inst_cache_CYC_I = 1'b0;
                inst_cache_STB_I = 1'b0;
                aborted = 1'b1;
            end
            if (abort_at == 0 && ack_cyc != 0) done = 1'b1;
            if (abort_at > 0 && consumed_cyc != 0 && cyc >= consumed_cyc + 2) done = 1'b1;
        end
        check_eq("completed", 32'(done), 32'd1);
        if (abort_at == 0) begin
            check_eq("hit_vs_model", 32'(refill_cycles == 0), 32'(hit_m));
            if (exp_hit >= 0) check_eq("hit_vs_plan", 32'(refill_cycles == 0), 32'(exp_hit));
            if (hit_m) check_eq("hit_latency", 32'(ack_cyc), 32'd1);
            else       check_eq("miss_latency", 32'(ack_cyc), 32'(consumed_cyc));
        end else begin
            check_eq("abort_no_ack", 32'(ack_cyc), 32'd0);
            check_eq("abort_filled", 32'(consumed_cyc != 0), 32'd1);
        end
        if (!hit_m) model_fill(addr);
        @(posedge clk);
        #1;
        inst_cache_CYC_I = 1'b0;
        inst_cache_STB_I = 1'b0;
    endtask

    initial begin
        bit seen;
        RST_I            = 1'b1;
        inst_cache_CYC_I = 1'b0;
        inst_cache_STB_I = 1'b0;
        inst_cache_ADR_I = '0;
`ifdef INSTRUCTION_CACHE_FLUSH_EN
        flush_I          = 1'b0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        RST_I = 1'b0;
        check_eq("rst_cyc", 32'(inst_CYC_O), 32'd0);
        check_eq("rst_stb", 32'(inst_STB_O), 32'd0);
        check_eq("rst_ack", 32'(inst_cache_ACK_O), 32'd0);
        check_eq("rst_adr", inst_ADR_O, 32'd0);
        check_eq("rst_dat", inst_cache_DAT_O, 32'd0);

        // cold miss then same-line hit
        do_read(32'h100, 0, 0);
        do_read(32'h104, 1, 0);

        // conflict replacement in set 0
        do_read(32'h000, 0, 0);
        do_read(32'h200, 0, 0);
        do_read(32'h400, 0, 0);
        do_read(32'h200, 1, 0);
        do_read(32'h000, 0, 0);
        do_read(32'h200, 0, 0);

        // requester abort during refill still fills the line
        force_delay = 4;
        do_read(32'h140, -1, 2);
        force_delay = -1;
        do_read(32'h144, 1, 0);

        // reset in the middle of a refill
        force_delay = 30;
        inst_cache_CYC_I = 1'b1;
        inst_cache_STB_I = 1'b1;
        inst_cache_ADR_I = 32'h2C0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = inst_CYC_O;
        end
        check_eq("rst_mid_refill_started", 32'(seen), 32'd1);
        RST_I = 1'b1;
        inst_cache_CYC_I = 1'b0;
        inst_cache_STB_I = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_mid_cyc", 32'(inst_CYC_O), 32'd0);
        check_eq("rst_mid_stb", 32'(inst_STB_O), 32'd0);
        RST_I = 1'b0;
        model_reset();
        force_delay = -1;
        do_read(32'h2C0, 0, 0);
        do_read(32'h104, 0, 0);

`ifdef INSTRUCTION_CACHE_FLUSH_EN
        do_read(32'h100, 1, 0);
        flush_I = 1'b1;
        @(posedge clk);
        #1;
        flush_I = 1'b0;
        check_eq("flush_ack", 32'(flush_ACK_O), 32'd1);
        model_reset();
        do_read(32'h100, 0, 0);
`endif

        // randomised traffic over a small footprint to provoke hits and evictions
        for (int n = 0; n < 60; n++) begin
            do_read((32'($urandom_range(0, 5)) << 9) | (32'($urandom_range(0, 7)) << 6) |
                    (32'($urandom_range(0, 15)) << 2), -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
